// File: rtl/serializador_paralelo_serie_pkg.sv
// Shared definitions for the serializer and the downstream detector stage:
// state codes and the default word width.
package serializador_paralelo_serie_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;

endpackage

// File: rtl/serializador_paralelo_serie_contador_bits.sv
// Bit counter for the serializer: counts 0..WIDTH-1 and flags the last bit.
// The terminal count gates both the ready handshake and the exit from SHIFT.
module contador_bits #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] count_q, count_d;

    // Clear has priority so a reload on the last bit restarts at zero.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serializador_paralelo_serie.sv
// Parallel-to-serial converter: accepts a word on load&&ready and streams it
// one bit per clock, reloading on the last bit so consecutive words abut.
module serializador_paralelo_serie
    import serializador_paralelo_serie_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shifted;
    logic             tc;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_en;

    contador_bits #(
        .WIDTH (WIDTH)
    ) u_contador_bits (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (tc)
    );

    // The serial bit always comes from a register edge, never from data_in.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shifted = {shreg_q[WIDTH-2:0], 1'b0};
            assign dout    = shreg_q[WIDTH-1];
        end else begin : g_lsb_first
            assign shifted = {1'b0, shreg_q[WIDTH-1:1]};
            assign dout    = shreg_q[0];
        end
    endgenerate

    assign ready      = (state_q == ST_IDLE) || ((state_q == ST_SHIFT) && tc);
    assign accept     = load && ready;
    assign busy       = (state_q == ST_SHIFT);
    assign dout_valid = busy;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d = data_in;
                    state_d = ST_SHIFT;
                    cnt_clr = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!tc) begin
                    shreg_d = shifted;
                    cnt_en  = 1'b1;
                end else if (accept) begin
                    shreg_d = data_in;
                    cnt_clr = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    shreg_d = '0;
                    cnt_clr = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                shreg_d = '0;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: tb/tb_serializador_paralelo_serie.sv
// Scoreboard bench for the serializer: an MSB-first 8-bit instance and an
// LSB-first 4-bit instance, checked bit by bit against expected-bit queues.
module tb_serializador_paralelo_serie;

    logic       clk = 1'b0;
    logic       rst;
    logic       load8, load4;
    logic [7:0] din8;
    logic [3:0] din4;
    logic       rdy8, dout8, vld8, busy8;
    logic       rdy4, dout4, vld4, busy4;

    int n_cmp = 0;
    int n_bad = 0;

    bit q8[$];
    bit q4[$];

    always #5 clk = ~clk;

    serializador_paralelo_serie #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .clk(clk), .rst(rst), .data_in(din8), .load(load8),
        .ready(rdy8), .dout(dout8), .dout_valid(vld8), .busy(busy8)
    );

    serializador_paralelo_serie #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
        .clk(clk), .rst(rst), .data_in(din4), .load(load4),
        .ready(rdy4), .dout(dout4), .dout_valid(vld4), .busy(busy4)
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected completion at %0t", name, $time);
    endtask

    // Monitors: queue length before popping is the number of bits still owed,
    // so ready must be high exactly when at most one bit remains.
    always @(negedge clk) begin
        if (rst) begin
            check("rst8_valid", vld8, 1'b0);
            check("rst8_ready", rdy8, 1'b1);
            check("rst8_dout", dout8, 1'b0);
        end else begin
            check("ready8", rdy8, q8.size() <= 1);
            check("busy8", busy8, q8.size() != 0);
            check("valid8", vld8, q8.size() != 0);
            if (q8.size() != 0) check("dout8", dout8, q8.pop_front());
            else check("idle_dout8", dout8, 1'b0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst4_valid", vld4, 1'b0);
            check("rst4_ready", rdy4, 1'b1);
            check("rst4_dout", dout4, 1'b0);
        end else begin
            check("ready4", rdy4, q4.size() <= 1);
            check("busy4", busy4, q4.size() != 0);
            check("valid4", vld4, q4.size() != 0);
            if (q4.size() != 0) check("dout4", dout4, q4.pop_front());
            else check("idle_dout4", dout4, 1'b0);
        end
    end

    // One driver cycle: inputs change just after the falling edge, so ready
    // is already settled for the coming rising edge.
    task automatic cyc(input logic l8, input logic [7:0] d8, input logic l4,
                       input logic [3:0] d4, output logic a8, output logic a4);
        @(negedge clk);
        #1;
        load8 = l8; din8 = d8; load4 = l4; din4 = d4;
        a8 = l8 && rdy8;
        a4 = l4 && rdy4;
        if (a8) for (int i = 7; i >= 0; i--) q8.push_back(d8[i]);
        if (a4) for (int i = 0; i <= 3; i++) q4.push_back(d4[i]);
    endtask

    task automatic idle(input int n);
        logic a8, a4;
        repeat (n) cyc(1'b0, 8'($urandom), 1'b0, 4'($urandom), a8, a4);
    endtask

    task automatic send8(input logic [7:0] d);
        logic a8, a4;
        a8 = 1'b0;
        for (int k = 0; k < 40 && !a8; k++) cyc(1'b1, d, 1'b0, 4'h0, a8, a4);
        if (!a8) timeout("send8");
    endtask

    task automatic send4(input logic [3:0] d);
        logic a8, a4;
        a4 = 1'b0;
        for (int k = 0; k < 40 && !a4; k++) cyc(1'b0, 8'h00, 1'b1, d, a8, a4);
        if (!a4) timeout("send4");
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (q8.size() != 0 || q4.size() != 0); k++) idle(1);
        idle(2);
        if (q8.size() != 0 || q4.size() != 0) timeout("drain");
    endtask

    // Asynchronous reset in mid-cycle: outputs must drop before any edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        load8 = 1'b0;
        load4 = 1'b0;
        #1;
        check("async_dout8", dout8, 1'b0);
        check("async_valid8", vld8, 1'b0);
        check("async_busy8", busy8, 1'b0);
        check("async_ready8", rdy8, 1'b1);
        check("async_valid4", vld4, 1'b0);
        q8.delete();
        q4.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic a8, a4;
        rst = 1'b1; load8 = 1'b0; load4 = 1'b0; din8 = '0; din4 = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Single word, MSB first: 1,0,1,0,0,1,0,1 then idle.
        send8(8'hA5);
        drain();

        // Back-to-back with load held high: 16 contiguous bits.
        send8(8'hA0);
        send8(8'h5F);
        drain();

        // Reset in the middle of a word discards the remaining bits.
        send8(8'hFF);
        idle(3);
        async_reset();
        idle(12);

        // A load pulse while busy is ignored.
        send8(8'h0F);
        idle(1);
        cyc(1'b1, 8'hF0, 1'b0, 4'h0, a8, a4);
        drain();

        // LSB-first 4-bit instance: 4'b0001 -> 1,0,0,0.
        send4(4'b0001);
        send4(4'b1010);
        drain();

        // Random traffic on both instances, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset();
            else cyc(($urandom_range(0, 2) != 0), 8'($urandom),
                     ($urandom_range(0, 2) != 0), 4'($urandom), a8, a4);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
